// File: rtl/ysyx_25020037_exu.sv
// Execute stage: combinational ALU feeding a one-entry output buffer,
// a one-cycle fetch redirect for taken branches/jumps, and branch counters.
//
// ALU one-hot op map (bit index):
//   0 add   1 sub   2 sll   3 slt   4 sltu  5 xor   6 srl   7 sra
//   8 or    9 and  10 lui (passes src2)
//  11 beq  12 bne  13 blt  14 bge  15 bltu 16 bgeu

module ysyx_25020037_alu (
  input  logic [16:0] alu_op,
  input  logic        double_cal,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic [31:0] src4,
  output logic [31:0] alu_result1,
  output logic        alu_result2
);
  logic [31:0] sum;
  logic [31:0] sra_res;
  logic        lt_s;
  logic        lt_u;
  logic        cmp_lt_s;
  logic        cmp_lt_u;
  logic        cmp_eq;

  assign sum      = src1 + src2;
  assign sra_res  = 32'($signed(src1) >>> src2[4:0]);
  assign lt_s     = $signed(src1) < $signed(src2);
  assign lt_u     = src1 < src2;
  assign cmp_eq   = src3 == src4;
  assign cmp_lt_s = $signed(src3) < $signed(src4);
  assign cmp_lt_u = src3 < src4;

  // Select the result: branches/jumps always add src1+src2 and compare src3/src4.
  always_comb begin
    alu_result1 = '0;
    alu_result2 = 1'b0;
    if (double_cal) begin
      alu_result1 = sum;
      alu_result2 = (alu_op[11] &  cmp_eq)   | (alu_op[12] & ~cmp_eq)   |
                    (alu_op[13] &  cmp_lt_s) | (alu_op[14] & ~cmp_lt_s) |
                    (alu_op[15] &  cmp_lt_u) | (alu_op[16] & ~cmp_lt_u);
    end else begin
      alu_result1 = ({32{alu_op[0]}}  & sum)
                  | ({32{alu_op[1]}}  & (src1 - src2))
                  | ({32{alu_op[2]}}  & (src1 << src2[4:0]))
                  | ({32{alu_op[3]}}  & {31'b0, lt_s})
                  | ({32{alu_op[4]}}  & {31'b0, lt_u})
                  | ({32{alu_op[5]}}  & (src1 ^ src2))
                  | ({32{alu_op[6]}}  & (src1 >> src2[4:0]))
                  | ({32{alu_op[7]}}  & sra_res)
                  | ({32{alu_op[8]}}  & (src1 | src2))
                  | ({32{alu_op[9]}}  & (src1 & src2))
                  | ({32{alu_op[10]}} & src2);
    end
  end
endmodule

module ysyx_25020037_exu (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [16:0] in_alu_op,
  input  logic        in_double_cal,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [31:0] in_src3,
  input  logic [31:0] in_src4,
  input  logic        in_is_jal,
  input  logic        in_is_jalr,
  input  logic [4:0]  in_rd,
  input  logic        in_rf_we,
  input  logic        in_mem_re,
  input  logic        in_mem_we,
  input  logic [2:0]  in_mem_size,
  input  logic [31:0] in_store_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_rf_we,
  output logic        out_mem_re,
  output logic        out_mem_we,
  output logic [2:0]  out_mem_size,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt
);
  logic        out_valid_q;
  logic [31:0] out_pc_q, out_result_q, out_store_data_q;
  logic [4:0]  out_rd_q;
  logic        out_rf_we_q, out_mem_re_q, out_mem_we_q;
  logic [2:0]  out_mem_size_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] branch_cnt_q, taken_cnt_q;

  logic [31:0] alu_result1;
  logic        alu_result2;
  logic        accept;
  logic        is_branch;
  logic        is_jump;
  logic        taken;
  logic [31:0] target;
  logic [31:0] result_d;

  ysyx_25020037_alu u_alu (
    .alu_op      (in_alu_op),
    .double_cal  (in_double_cal),
    .src1        (in_src1),
    .src2        (in_src2),
    .src3        (in_src3),
    .src4        (in_src4),
    .alu_result1 (alu_result1),
    .alu_result2 (alu_result2)
  );

  // While a redirect is on the wire the IDU is flushing, so nothing is taken.
  assign in_ready  = ~redirect_valid_q & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_jump   = in_double_cal & (in_is_jal | in_is_jalr);
  assign is_branch = in_double_cal & ~in_is_jal & ~in_is_jalr;
  assign taken     = is_branch ? alu_result2 : is_jump;
  assign target    = {alu_result1[31:1], alu_result1[0] & ~in_is_jalr};
  assign result_d  = is_jump ? (in_pc + 32'd4) : alu_result1;

  // Output buffer, redirect pulse and branch statistics.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_result_q     <= '0;
      out_store_data_q <= '0;
      out_rd_q         <= '0;
      out_rf_we_q      <= 1'b0;
      out_mem_re_q     <= 1'b0;
      out_mem_we_q     <= 1'b0;
      out_mem_size_q   <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      redirect_valid_q <= accept & taken;
      if (accept) begin
        out_valid_q      <= 1'b1;
        out_pc_q         <= in_pc;
        out_result_q     <= result_d;
        out_store_data_q <= in_store_data;
        out_rd_q         <= in_rd;
        out_rf_we_q      <= in_rf_we & ~is_branch;
        out_mem_re_q     <= in_mem_re & ~is_branch;
        out_mem_we_q     <= in_mem_we & ~is_branch;
        out_mem_size_q   <= in_mem_size;
        if (taken) begin
          redirect_pc_q <= target;
        end
        if (is_branch) begin
          branch_cnt_q <= branch_cnt_q + 32'd1;
          if (alu_result2) begin
            taken_cnt_q <= taken_cnt_q + 32'd1;
          end
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_result     = out_result_q;
  assign out_store_data = out_store_data_q;
  assign out_rd         = out_rd_q;
  assign out_rf_we      = out_rf_we_q;
  assign out_mem_re     = out_mem_re_q;
  assign out_mem_we     = out_mem_we_q;
  assign out_mem_size   = out_mem_size_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;
endmodule

// File: doc/ysyx_25020037_exu.md
# ysyx_25020037_exu

Execute stage of the ysyx_25020037 core, between the decode stage (IDU) and the load/store stage (LSU). It accepts one decoded instruction at a time over a valid/ready handshake and drives the combinational ysyx_25020037_alu. It registers the result, memory control and writeback control into a one-entry output buffer. For taken branches and jumps it issues a one-cycle redirect to instruction fetch, and it keeps branch statistics counters.

## Interface
- No parameters.
- clock  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  IDU holds a valid decoded instruction.
- in_ready  out  1  EXU can accept this cycle.
- in_pc  in  32  instruction PC.
- in_alu_op  in  17  one-hot ALU op, passed to the ALU alu_op input unchanged.
- in_double_cal  in  1  1 for conditional branches and jumps: the ALU computes both src1+src2 and the compare of src3 against src4.
- in_src1, in_src2  in  32 each  ALU operands 1 and 2 (operand 1 and operand 2 of the add/compare result).
- in_src3, in_src4  in  32 each  ALU compare operands 3 and 4.
- in_is_jal, in_is_jalr  in  1 each  unconditional jump flags, mutually exclusive.
- in_rd  in  5  destination register index.
- in_rf_we  in  1  register-file write enable.
- in_mem_re, in_mem_we  in  1 each  load / store.
- in_mem_size  in  3  funct3 of the load or store.
- in_store_data  in  32  rs2 value for stores.
- out_valid  out  1  output buffer holds an instruction.
- out_ready  in  1  LSU accepts.
- out_pc, out_result, out_store_data  out  32 each  registered PC, result, and store data.
- out_rd  out  5  registered destination index.
- out_rf_we, out_mem_re, out_mem_we  out  1 each  registered control flags.
- out_mem_size  out  3  registered memory size.
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  32  redirect target.
- branch_cnt, taken_cnt  out  32 each  count of retired conditional branches, and of those taken.

## Operation
- Accept when in_valid & in_ready.
- in_ready = ~redirect_valid & (~out_valid | out_ready).
- Conditional branch (in_double_cal=1, jal=jalr=0):
  - target = alu_result1;
  - taken = alu_result2;
  - registered out_rf_we, out_mem_re and out_mem_we are forced to 0.
- Jump (in_is_jal or in_is_jalr, with in_double_cal=1 and no branch op set):
  - target = alu_result1, with bit 0 cleared for jalr;
  - taken = 1;
  - out_result = in_pc + 4, wrapping modulo 2^32.
- Other instructions (in_double_cal=0): out_result = alu_result1.
  - For loads and stores this result is the effective address.
- No misaligned-target check; the LSU and fetch handle alignment.
- Taken control transfer on accept:
  - the next cycle has redirect_valid=1 and redirect_pc=target;
  - redirect_valid is never high for two consecutive cycles.
- IDU must drop its held instruction when redirect_valid=1.
  - in_ready=0 in that cycle, so no wrong-path instruction is accepted.
- Counters:
  - branch_cnt increments on accept of a conditional branch;
  - taken_cnt additionally increments if that branch is taken;
  - both wrap 0xFFFFFFFF -> 0;
  - jumps are not counted.
- Output buffer:
  - loads on accept;
  - out_valid clears on out_valid & out_ready & ~accept;
  - on simultaneous drain and accept the buffer reloads with the new instruction and out_valid stays 1.
- Output payload is stable while out_valid & ~out_ready.

## Timing
- Latency: accept at cycle N -> out_valid and payload at cycle N+1; redirect at N+1.
- Throughput: 1 instruction per cycle with out_ready=1 and no taken control transfers.
- Each taken branch or jump costs one bubble: in_ready=0 at N+1.
- ALU path is combinational from in_* to the buffer D inputs; there is no registered ALU input.
- Reset (reset_n=0 at a rising edge) forces all outputs to 0 at the next cycle:
  - out_valid, redirect_valid, redirect_pc, all payload registers, branch_cnt and taken_cnt;
  - in_ready is then 1.
- Reset asserted mid-operation discards the buffered instruction and any pending redirect.

## Test plan
- ADD: alu_op[0], src1=5, src2=7 -> next cycle out_valid=1, out_result=12, redirect_valid=0.
- BEQ taken: pc=0x80000010, src1=pc, src2=0x20, src3=src4=3 -> redirect_valid=1 for one cycle, redirect_pc=0x80000030, in_ready=0 that cycle, branch_cnt=1, taken_cnt=1.
- BLTU not taken: src3=5, src4=2 -> no redirect, branch_cnt +1, taken_cnt unchanged.
- JALR: pc=0x80000100, src1=0x80000203, src2=0 -> redirect_pc=0x80000202, out_result=0x80000104, out_rf_we=1.
- Back-pressure: out_ready=0 for 3 cycles after a SUB 9-4:
  - out_result=5 held stable;
  - in_ready=0 while the buffer is full;
  - after out_ready=1, the next instruction is accepted the same cycle.
- Reset mid-stream: reset_n=0 while out_valid=1 and the redirect pulse is due -> next cycle all outputs 0; counters start at 0.
